matrix_loader: RTL and testbench

- Upstream feeder for the matrix multiply unit.
- Accepts a word-serial stream of DATA_SIZE-bit elements over a valid/ready handshake and assembles them into the vector operand (datsA) and the matrix operand (datsB).
- Once both operands are complete, issues a one-cycle enable to the multiply unit, waits out its result latency, then signals done so the consumer can sample the result.

---
 rtl/matrix_loader.sv | 184 ++++++++++++++++++
 tb/tb_matrix_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// ============================================================================
// Module   : matrix_loader
// Purpose  : Assembles a word-serial element stream into the vector (datsA) and
//            matrix (datsB) operands, fires the multiply unit, flags its result.
// Option   : MATLOAD_KEEP_B_EN enables keep_b (reuse resident datsB).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module matrix_loader #(
    parameter int DATA_SIZE   = 8,
    parameter int COLUMN_SIZE = 64,
    parameter int ROW_SIZE    = 64,
    parameter int MUL_LATENCY = 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   keep_b,
    input  logic                                   in_valid,
    input  logic [DATA_SIZE-1:0]                   in_data,
    output logic                                   in_ready,
    output logic [DATA_SIZE*COLUMN_SIZE-1:0]       datsA,
    output logic [DATA_SIZE*COLUMN_SIZE*ROW_SIZE-1:0] datsB,
    output logic                                   mat_enable,
    output logic                                   busy,
    output logic                                   done
);

    localparam int A_WIDTH = DATA_SIZE * COLUMN_SIZE;
    localparam int B_ELEMS = COLUMN_SIZE * ROW_SIZE;
    localparam int B_WIDTH = DATA_SIZE * B_ELEMS;
    localparam int CNT_W   = $clog2(B_ELEMS) + 1;
    localparam int LAT_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_FIRE   = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [A_WIDTH-1:0]   datsa_q, datsa_d;
    logic [B_WIDTH-1:0]   datsb_q, datsb_d;
    logic                 in_ready_q, in_ready_d;
    logic                 mat_enable_q, mat_enable_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 skip_b;
    logic                 accept;

`ifdef MATLOAD_KEEP_B_EN
    logic keep_q, keep_d;
    assign skip_b = keep_q;
`else
    logic unused_keep_b;
    assign unused_keep_b = keep_b;
    assign skip_b        = 1'b0;
`endif

    // in_ready_q is high exactly in the load states, so it doubles as the gate
    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        datsa_d = datsa_q;
        datsb_d = datsb_q;
`ifdef MATLOAD_KEEP_B_EN
        keep_d  = keep_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                    cnt_d   = '0;
`ifdef MATLOAD_KEEP_B_EN
                    keep_d  = keep_b;
`endif
                end
            end
            S_LOAD_A: begin
                if (accept) begin
                    for (int i = 0; i < COLUMN_SIZE; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            datsa_d[i*DATA_SIZE +: DATA_SIZE] = in_data;
                        end
                    end
                    if (cnt_q == CNT_W'(COLUMN_SIZE - 1)) begin
                        cnt_d   = '0;
                        state_d = skip_b ? S_FIRE : S_LOAD_B;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LOAD_B: begin
                if (accept) begin
                    for (int i = 0; i < B_ELEMS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            datsb_d[i*DATA_SIZE +: DATA_SIZE] = in_data;
                        end
                    end
                    if (cnt_q == CNT_W'(B_ELEMS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_FIRE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_FIRE: begin
                state_d = S_WAIT;
                lat_d   = LAT_W'(MUL_LATENCY);
            end
            S_WAIT: begin
                // Leaving at value 1 gives done exactly MUL_LATENCY+1 cycles after FIRE
                if (lat_q <= LAT_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d   = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
        mat_enable_d = (state_d == S_FIRE);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            lat_q        <= '0;
            datsa_q      <= '0;
            datsb_q      <= '0;
            in_ready_q   <= 1'b0;
            mat_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef MATLOAD_KEEP_B_EN
            keep_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_q        <= lat_d;
            datsa_q      <= datsa_d;
            datsb_q      <= datsb_d;
            in_ready_q   <= in_ready_d;
            mat_enable_q <= mat_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef MATLOAD_KEEP_B_EN
            keep_q       <= keep_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign datsA      = datsa_q;
    assign datsB      = datsb_q;
    assign mat_enable = mat_enable_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_loader.sv
// ============================================================================
// Module   : tb_matrix_loader
// Purpose  : Directed self-checking bench for matrix_loader (2x2, 8-bit).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_matrix_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic        start4;
    logic        keep_b;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        in_ready,  in_ready4;
    logic [15:0] datsA,     datsA4;
    logic [31:0] datsB,     datsB4;
    logic        mat_enable, mat_enable4;
    logic        busy,      busy4;
    logic        done,      done4;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int me_cnt;
    int done_cnt;

    matrix_loader #(
        .DATA_SIZE(8), .COLUMN_SIZE(2), .ROW_SIZE(2), .MUL_LATENCY(1)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .keep_b(keep_b),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .datsA(datsA), .datsB(datsB), .mat_enable(mat_enable),
        .busy(busy), .done(done)
    );

    matrix_loader #(
        .DATA_SIZE(8), .COLUMN_SIZE(2), .ROW_SIZE(2), .MUL_LATENCY(4)
    ) dut4 (
        .clock(clock), .reset(reset), .start(start4), .keep_b(keep_b),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
        .datsA(datsA4), .datsB(datsB4), .mat_enable(mat_enable4),
        .busy(busy4), .done(done4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 20 && in_ready !== 1'b1; k++) step();
        chk("push_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic gap();
        in_valid = 1'b0;
        in_data  = 8'hEE;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; start4 = 1'b0; keep_b = 1'b0;
        in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mat_enable", mat_enable, 0);
        chk("rst_done", done, 0);
        chk("rst_datsA", datsA, 0);
        chk("rst_datsB", datsB, 0);
        reset = 1'b1;
        step();

        // continuous stream, both latencies in parallel
        start = 1'b1; start4 = 1'b1;
        step();
        start = 1'b0; start4 = 1'b0;
        chk("t1_busy", busy, 1);
        push(8'h11); push(8'h22); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        chk("t1_mat_enable", mat_enable, 1);
        chk("t1_in_ready", in_ready, 0);
        chk("t1_datsA", datsA, 16'h2211);
        chk("t1_datsB", datsB, 32'h04030201);
        chk("t1_mat_enable4", mat_enable4, 1);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("t1_done", done, (k == 2));
            chk("t1_me_low", mat_enable, 0);
            chk("t1_busy_seq", busy, (k < 3));
            chk("t1_done4", done4, (k == 5));
            chk("t1_busy4", busy4, (k < 6));
        end
        chk("t1_datsA_held", datsA, 16'h2211);

        // stream with in_valid gaps
        start = 1'b1;
        step();
        start = 1'b0;
        push(8'h55);
        chk("t2_partialA", datsA, 16'h2255);
        gap();
        chk("t2_gap_ready", in_ready, 1);
        chk("t2_gap_datsA", datsA, 16'h2255);
        push(8'h66); gap();
        push(8'hA1); gap();
        push(8'hA2); gap();
        chk("t2_gap_datsB", datsB, 32'h0403A2A1);
        push(8'hA3); gap();
        chk("t2_no_fire_early", mat_enable, 0);
        push(8'hA4);
        chk("t2_mat_enable", mat_enable, 1);
        chk("t2_datsA", datsA, 16'h6655);
        chk("t2_datsB", datsB, 32'hA4A3A2A1);
        step(); step();
        chk("t2_done", done, 1);
        step();
        chk("t2_idle", busy, 0);

        // start pulses during LOAD_B and WAIT are ignored
        start = 1'b1;
        step();
        start = 1'b0;
        push(8'h77); push(8'h88);
        start = 1'b1;
        push(8'hC1);
        start = 1'b0;
        push(8'hC2); push(8'hC3); push(8'hC4);
        chk("t3_mat_enable", mat_enable, 1);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        me_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (done === 1'b1) done_cnt++;
            if (mat_enable === 1'b1) me_cnt++;
            step();
        end
        chk("t3_done_count", done_cnt, 1);
        chk("t3_extra_fire", me_cnt, 0);
        chk("t3_idle", busy, 0);
        chk("t3_datsA", datsA, 16'h8877);
        chk("t3_datsB", datsB, 32'hC4C3C2C1);

        // asynchronous reset mid LOAD_B, then a fresh transaction
        start = 1'b1;
        step();
        start = 1'b0;
        push(8'hD1); push(8'hD2); push(8'hE1);
        reset = 1'b0;
        #2;
        chk("t5_in_ready", in_ready, 0);
        chk("t5_busy", busy, 0);
        chk("t5_datsA", datsA, 0);
        chk("t5_datsB", datsB, 0);
        chk("t5_mat_enable", mat_enable, 0);
        chk("t5_done", done, 0);
        @(negedge clock);
        reset = 1'b1;
        step();
        chk("t5_still_idle", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        push(8'h11); push(8'h22); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        chk("t5_mat_enable", mat_enable, 1);
        chk("t5_datsA_new", datsA, 16'h2211);
        chk("t5_datsB_new", datsB, 32'h04030201);
        step(); step();
        chk("t5_done_new", done, 1);
        step();

        // keep_b request: honoured only with the option compiled in
        keep_b = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        keep_b = 1'b0;
        push(8'h33); push(8'h44);
        chk("t6_datsA", datsA, 16'h4433);
        chk("t6_datsB_kept", datsB, 32'h04030201);
`ifdef MATLOAD_KEEP_B_EN
        chk("t6_mat_enable", mat_enable, 1);
        chk("t6_in_ready", in_ready, 0);
`else
        chk("t6_no_fire", mat_enable, 0);
        chk("t6_in_ready", in_ready, 1);
        push(8'hF1); push(8'hF2); push(8'hF3); push(8'hF4);
        chk("t6_mat_enable", mat_enable, 1);
        chk("t6_datsB_new", datsB, 32'hF4F3F2F1);
`endif
        step(); step();
        chk("t6_done", done, 1);
        step();
        chk("t6_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
